instruction_decode: RTL and testbench

- ID stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
- Consumes pc/pc+4/instruction from the IF/ID register.
- Contains the 32x32 register file (written by WB), immediate generator, control decoder, load-use hazard detector and the ID/EX pipeline register.
- Drives `stall` back to IF and all operands and controls to EX.

---
 rtl/instruction_decode.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I ID stage: register file, decoder, load-use detect, ID/EX register
//
// Decodes the instruction held in IF/ID, reads its operands from the 32x32
// register file (with write-through from WB), generates the immediate and
// control word, detects load-use hazards and registers everything into ID/EX.
//
// Ports:
//   clk, reset            stage clock, asynchronous active-low reset
//   *_IFID                instruction, PC and PC+4 from IF/ID
//   pc_sel_EXIF           taken branch/jump in EX: flush ID/EX
//   mmm_stall             matrix-multiply busy: freeze ID/EX
//   wb_en/wb_rd/wb_data   register-file write port from WB
//   stall                 load-use hazard, IF holds PC and IF/ID
//   *_IDEX                operands, indices and controls for EX
module instruction_decode #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction_IFID,
  input  logic [WIDTH-1:0] pc_IFID,
  input  logic [WIDTH-1:0] pc_4_IFID,
  input  logic             pc_sel_EXIF,
  input  logic             mmm_stall,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall,
  output logic [WIDTH-1:0] pc_IDEX,
  output logic [WIDTH-1:0] pc_4_IDEX,
  output logic [WIDTH-1:0] rs1_data_IDEX,
  output logic [WIDTH-1:0] rs2_data_IDEX,
  output logic [WIDTH-1:0] imm_IDEX,
  output logic [4:0]       rs1_IDEX,
  output logic [4:0]       rs2_IDEX,
  output logic [4:0]       rd_IDEX,
  output logic [2:0]       funct3_IDEX,
  output logic [3:0]       alu_op_IDEX,
  output logic             alu_src_a_IDEX,
  output logic             alu_src_b_IDEX,
  output logic             mem_read_IDEX,
  output logic             mem_write_IDEX,
  output logic             reg_write_IDEX,
  output logic [1:0]       wb_sel_IDEX,
  output logic             branch_IDEX,
  output logic             jal_IDEX,
  output logic             jalr_IDEX,
  output logic             illegal_IDEX
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_4;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [3:0]       alu_op;
    logic             alu_src_a;
    logic             alu_src_b;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             illegal;
  } idex_t;

  // alt selects SUB for funct3=0 and SRA for funct3=5; callers only set it when legal.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [WIDTH-1:0] instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rs1_f, rs2_f, rd_f;

  assign instr  = instruction_IFID;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign funct7 = instr[31:25];

  // Register file; entry 0 is never written so it stays at its reset value.
  logic [WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  logic [WIDTH-1:0] rs1_val, rs2_val;

  // Write-through lets an instruction in ID see the value WB writes this cycle.
  always_comb begin
    rs1_val = regs[rs1_f];
    if (rs1_f == 5'd0)                    rs1_val = '0;
    else if (wb_en && wb_rd == rs1_f)     rs1_val = wb_data;
    rs2_val = regs[rs2_f];
    if (rs2_f == 5'd0)                    rs2_val = '0;
    else if (wb_en && wb_rd == rs2_f)     rs2_val = wb_data;
  end

  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [3:0]       d_alu_op;
  logic             d_src_a, d_src_b, d_mem_read, d_mem_write, d_reg_write;
  logic [1:0]       d_wb_sel;
  logic             d_branch, d_jal, d_jalr;
  logic [WIDTH-1:0] d_imm;
  logic             legal, uses_rs1, uses_rs2;

  always_comb begin
    d_alu_op    = ALU_ADD;
    d_src_a     = 1'b0;
    d_src_b     = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_reg_write = 1'b0;
    d_wb_sel    = WB_ALU;
    d_branch    = 1'b0;
    d_jal       = 1'b0;
    d_jalr      = 1'b0;
    d_imm       = '0;
    legal       = 1'b1;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs2    = 1'b1;
        d_reg_write = 1'b1;
        d_alu_op    = alu_from_funct3(funct3, funct7[5]);
        legal       = (funct7 == 7'h00) ||
                      (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
      end
      OPC_OPIMM: begin
        d_imm       = imm_i;
        d_src_b     = 1'b1;
        d_reg_write = 1'b1;
        // No SUBI: imm[10] only distinguishes SRAI from SRLI.
        d_alu_op    = alu_from_funct3(funct3, funct3 == 3'd5 && instr[30]);
        if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      OPC_LOAD: begin
        d_imm       = imm_i;
        d_src_b     = 1'b1;
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
        d_wb_sel    = WB_MEM;
        legal       = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      end
      OPC_STORE: begin
        uses_rs2    = 1'b1;
        d_imm       = imm_s;
        d_src_b     = 1'b1;
        d_mem_write = 1'b1;
        legal       = (funct3 < 3'd3);
      end
      OPC_BRANCH: begin
        uses_rs2    = 1'b1;
        d_imm       = imm_b;
        d_alu_op    = ALU_SUB;
        d_branch    = 1'b1;
        legal       = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPC_LUI: begin
        uses_rs1    = 1'b0;
        d_imm       = imm_u;
        d_alu_op    = ALU_PASS_B;
        d_src_b     = 1'b1;
        d_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        uses_rs1    = 1'b0;
        d_imm       = imm_u;
        d_src_a     = 1'b1;
        d_src_b     = 1'b1;
        d_reg_write = 1'b1;
      end
      OPC_JAL: begin
        uses_rs1    = 1'b0;
        d_imm       = imm_j;
        d_jal       = 1'b1;
        d_reg_write = 1'b1;
        d_wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        d_imm       = imm_i;
        d_src_b     = 1'b1;
        d_jalr      = 1'b1;
        d_reg_write = 1'b1;
        d_wb_sel    = WB_PC4;
        legal       = (funct3 == 3'd0);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d_alu_op    = ALU_ADD;
      d_src_a     = 1'b0;
      d_src_b     = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_reg_write = 1'b0;
      d_wb_sel    = WB_ALU;
      d_branch    = 1'b0;
      d_jal       = 1'b0;
      d_jalr      = 1'b0;
    end
  end

  idex_t d, q;

  always_comb begin
    d           = '0;
    d.pc        = pc_IFID;
    d.pc_4      = pc_4_IFID;
    d.rs1_data  = rs1_val;
    d.rs2_data  = rs2_val;
    d.imm       = d_imm;
    d.rs1       = rs1_f;
    d.rs2       = rs2_f;
    // rd is only meaningful when the instruction writes back; otherwise it is imm bits.
    d.rd        = d_reg_write ? rd_f : 5'd0;
    d.funct3    = funct3;
    d.alu_op    = d_alu_op;
    d.alu_src_a = d_src_a;
    d.alu_src_b = d_src_b;
    d.mem_read  = d_mem_read;
    d.mem_write = d_mem_write;
    d.reg_write = d_reg_write;
    d.wb_sel    = d_wb_sel;
    d.branch    = d_branch;
    d.jal       = d_jal;
    d.jalr      = d_jalr;
    d.illegal   = !legal;
  end

  // A flush kills the consumer anyway, so no stall is needed behind it.
  assign stall = q.mem_read && (q.rd != 5'd0) &&
                 ((uses_rs1 && q.rd == rs1_f) || (uses_rs2 && q.rd == rs2_f)) &&
                 !pc_sel_EXIF;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           q <= '0;
    else if (pc_sel_EXIF) q <= '0;
    else if (mmm_stall)   q <= q;
    else if (stall)       q <= '0;
    else                  q <= d;
  end

  assign pc_IDEX        = q.pc;
  assign pc_4_IDEX      = q.pc_4;
  assign rs1_data_IDEX  = q.rs1_data;
  assign rs2_data_IDEX  = q.rs2_data;
  assign imm_IDEX       = q.imm;
  assign rs1_IDEX       = q.rs1;
  assign rs2_IDEX       = q.rs2;
  assign rd_IDEX        = q.rd;
  assign funct3_IDEX    = q.funct3;
  assign alu_op_IDEX    = q.alu_op;
  assign alu_src_a_IDEX = q.alu_src_a;
  assign alu_src_b_IDEX = q.alu_src_b;
  assign mem_read_IDEX  = q.mem_read;
  assign mem_write_IDEX = q.mem_write;
  assign reg_write_IDEX = q.reg_write;
  assign wb_sel_IDEX    = q.wb_sel;
  assign branch_IDEX    = q.branch;
  assign jal_IDEX       = q.jal;
  assign jalr_IDEX      = q.jalr;
  assign illegal_IDEX   = q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - bench for instruction_decode
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_IFID, pc_IFID, pc_4_IFID;
  logic        pc_sel_EXIF, mmm_stall, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] pc_IDEX, pc_4_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
  logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX;
  logic [2:0]  funct3_IDEX;
  logic [3:0]  alu_op_IDEX;
  logic        alu_src_a_IDEX, alu_src_b_IDEX, mem_read_IDEX, mem_write_IDEX, reg_write_IDEX;
  logic [1:0]  wb_sel_IDEX;
  logic        branch_IDEX, jal_IDEX, jalr_IDEX, illegal_IDEX;

  instruction_decode dut (
    .clk(clk), .reset(reset),
    .instruction_IFID(instruction_IFID), .pc_IFID(pc_IFID), .pc_4_IFID(pc_4_IFID),
    .pc_sel_EXIF(pc_sel_EXIF), .mmm_stall(mmm_stall),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall),
    .pc_IDEX(pc_IDEX), .pc_4_IDEX(pc_4_IDEX),
    .rs1_data_IDEX(rs1_data_IDEX), .rs2_data_IDEX(rs2_data_IDEX), .imm_IDEX(imm_IDEX),
    .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
    .funct3_IDEX(funct3_IDEX), .alu_op_IDEX(alu_op_IDEX),
    .alu_src_a_IDEX(alu_src_a_IDEX), .alu_src_b_IDEX(alu_src_b_IDEX),
    .mem_read_IDEX(mem_read_IDEX), .mem_write_IDEX(mem_write_IDEX),
    .reg_write_IDEX(reg_write_IDEX), .wb_sel_IDEX(wb_sel_IDEX),
    .branch_IDEX(branch_IDEX), .jal_IDEX(jal_IDEX), .jalr_IDEX(jalr_IDEX),
    .illegal_IDEX(illegal_IDEX)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, pc_4, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        src_a, src_b, mem_read, mem_write, reg_write;
    logic [1:0]  wb_sel;
    logic        branch, jal, jalr, illegal;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  exp_t        e;
  logic [31:0] mregs [32];
  logic [3:0]  alu_tbl [8];
  logic        last_stall = 1'b0;

  localparam logic [31:0] LW_X3   = 32'h0000A183;  // lw   x3,0(x1)
  localparam logic [31:0] ADD_USE = 32'h00218233;  // add  x4,x3,x2
  localparam logic [31:0] LUI_X3  = 32'h000181B7;  // lui  x3 (rs1 field = 3)
  localparam logic [31:0] ADDI_M3 = 32'hFFD00293;  // addi x5,x0,-3

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s (step %0d): observed %h expected %h", tag, step_no, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("pc_IDEX", pc_IDEX, e.pc);
    chk("pc_4_IDEX", pc_4_IDEX, e.pc_4);
    chk("rs1_data_IDEX", rs1_data_IDEX, e.rs1_data);
    chk("rs2_data_IDEX", rs2_data_IDEX, e.rs2_data);
    chk("imm_IDEX", imm_IDEX, e.imm);
    chk("rs1_IDEX", 32'(rs1_IDEX), 32'(e.rs1));
    chk("rs2_IDEX", 32'(rs2_IDEX), 32'(e.rs2));
    chk("rd_IDEX", 32'(rd_IDEX), 32'(e.rd));
    chk("funct3_IDEX", 32'(funct3_IDEX), 32'(e.funct3));
    chk("alu_op_IDEX", 32'(alu_op_IDEX), 32'(e.alu_op));
    chk("alu_src_a_IDEX", 32'(alu_src_a_IDEX), 32'(e.src_a));
    chk("alu_src_b_IDEX", 32'(alu_src_b_IDEX), 32'(e.src_b));
    chk("mem_read_IDEX", 32'(mem_read_IDEX), 32'(e.mem_read));
    chk("mem_write_IDEX", 32'(mem_write_IDEX), 32'(e.mem_write));
    chk("reg_write_IDEX", 32'(reg_write_IDEX), 32'(e.reg_write));
    chk("wb_sel_IDEX", 32'(wb_sel_IDEX), 32'(e.wb_sel));
    chk("branch_IDEX", 32'(branch_IDEX), 32'(e.branch));
    chk("jal_IDEX", 32'(jal_IDEX), 32'(e.jal));
    chk("jalr_IDEX", 32'(jalr_IDEX), 32'(e.jalr));
    chk("illegal_IDEX", 32'(illegal_IDEX), 32'(e.illegal));
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_en && wb_rd == r) return wb_data;
    return mregs[r];
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t r;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    r = '0; ok = 1'b1; f3 = ins[14:12]; f7 = ins[31:25];
    r.pc = pc_IFID; r.pc_4 = pc_4_IFID;
    r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.funct3 = f3;
    r.rs1_data = rf_read(ins[19:15]);
    r.rs2_data = rf_read(ins[24:20]);
    case (ins[6:0])
      7'h33: begin
        r.alu_op = alu_tbl[f3];
        if (f7 == 7'h20) r.alu_op = (f3 == 3'd0) ? 4'd1 : 4'd7;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        r.reg_write = 1'b1;
      end
      7'h13: begin
        r.imm = 32'($signed(ins[31:20]));
        r.src_b = 1'b1; r.reg_write = 1'b1;
        r.alu_op = alu_tbl[f3];
        if (f3 == 3'd5 && ins[30]) r.alu_op = 4'd7;
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h03: begin
        r.imm = 32'($signed(ins[31:20]));
        r.src_b = 1'b1; r.mem_read = 1'b1; r.reg_write = 1'b1; r.wb_sel = 2'd1;
        ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      end
      7'h23: begin
        r.imm = 32'($signed({ins[31:25], ins[11:7]}));
        r.src_b = 1'b1; r.mem_write = 1'b1;
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        r.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        r.alu_op = 4'd1; r.branch = 1'b1;
        ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h37: begin
        r.imm = {ins[31:12], 12'h000};
        r.alu_op = 4'd10; r.src_b = 1'b1; r.reg_write = 1'b1;
      end
      7'h17: begin
        r.imm = {ins[31:12], 12'h000};
        r.src_a = 1'b1; r.src_b = 1'b1; r.reg_write = 1'b1;
      end
      7'h6F: begin
        r.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        r.jal = 1'b1; r.reg_write = 1'b1; r.wb_sel = 2'd2;
      end
      7'h67: begin
        r.imm = 32'($signed(ins[31:20]));
        r.jalr = 1'b1; r.src_b = 1'b1; r.reg_write = 1'b1; r.wb_sel = 2'd2;
        ok = (f3 == 3'd0);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r.alu_op = 4'd0; r.src_a = 1'b0; r.src_b = 1'b0;
      r.mem_read = 1'b0; r.mem_write = 1'b0; r.reg_write = 1'b0; r.wb_sel = 2'd0;
      r.branch = 1'b0; r.jal = 1'b0; r.jalr = 1'b0; r.illegal = 1'b1;
    end
    r.rd = r.reg_write ? ins[11:7] : 5'd0;
    return r;
  endfunction

  function automatic logic ref_stall();
    logic [6:0] op;
    logic u1, u2;
    op = instruction_IFID[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return e.mem_read && e.rd != 5'd0 && !pc_sel_EXIF &&
           ((u1 && e.rd == instruction_IFID[19:15]) || (u2 && e.rd == instruction_IFID[24:20]));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      default: ;
    endcase
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic drive(input logic [31:0] ins);
    instruction_IFID = ins;
    pc_IFID = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
    pc_4_IFID = pc_IFID + 32'd4;
  endtask

  // One clock: stall checked before the edge, full ID/EX compare after it.
  task automatic tick();
    exp_t d, nxt;
    step_no++;
    #1;
    last_stall = ref_stall();
    chk("stall", 32'(stall), 32'(last_stall));
    d = ref_decode(instruction_IFID);
    if (pc_sel_EXIF)    nxt = '0;
    else if (mmm_stall) nxt = e;
    else if (last_stall) nxt = '0;
    else                nxt = d;
    @(posedge clk);
    if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
    e = nxt;
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_inputs();
    drive($urandom);
    pc_sel_EXIF = 1'($urandom); mmm_stall = 1'($urandom);
    wb_en = 1'b1; wb_rd = 5'($urandom); wb_data = $urandom;
  endtask

  initial begin
    alu_tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    e = '0;

    // Reset with random inputs.
    reset = 1'b0;
    rand_inputs();
    #1;
    check_all();
    chk("reset_stall", 32'(stall), 32'h0);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      rand_inputs();
      #1;
      check_all();
      chk("reset_stall", 32'(stall), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1; pc_sel_EXIF = 1'b0; mmm_stall = 1'b0; wb_en = 1'b0;

    // Every writable register reads zero after reset.
    for (int i = 1; i < 32; i++) begin
      drive({7'h00, 5'(i), 5'(i), 3'h0, 5'd0, 7'h33});
      tick();
      chk("x_after_reset", rs1_data_IDEX, 32'h0);
    end

    drive(ADDI_M3); tick();
    chk("addi_imm", imm_IDEX, 32'hFFFFFFFD);
    chk("addi_alu", 32'(alu_op_IDEX), 32'd0);
    chk("addi_srcb", 32'(alu_src_b_IDEX), 32'd1);
    chk("addi_rd", 32'(rd_IDEX), 32'd5);
    chk("addi_regwr", 32'(reg_write_IDEX), 32'd1);

    // Write-through from WB, and x0 ignoring writes.
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    drive(32'h00038433); tick();
    chk("wthru_rs1", rs1_data_IDEX, 32'hDEADBEEF);
    wb_rd = 5'd0; wb_data = 32'h12345678;
    drive(32'h00000433); tick();
    chk("x0_write", rs1_data_IDEX, 32'h0);
    wb_en = 1'b0;
    drive(32'h00038433); tick();
    chk("x7_stored", rs1_data_IDEX, 32'hDEADBEEF);

    // Load-use: one bubble, then the consumer is captured.
    drive(LW_X3); tick();
    drive(ADD_USE); #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble_rd", 32'(rd_IDEX), 32'd0);
    chk("lu_bubble_rw", 32'(reg_write_IDEX), 32'd0);
    #1;
    chk("lu_stall_once", 32'(stall), 32'd0);
    tick();
    chk("lu_capture_rd", 32'(rd_IDEX), 32'd4);
    chk("lu_capture_rw", 32'(reg_write_IDEX), 32'd1);

    drive(LW_X3); tick();
    drive(LUI_X3); #1;
    chk("lui_no_stall", 32'(stall), 32'd0);
    tick();
    chk("lui_alu", 32'(alu_op_IDEX), 32'd10);

    // Flush beats mmm_stall and the load-use stall.
    drive(LW_X3); tick();
    drive(ADD_USE); pc_sel_EXIF = 1'b1; mmm_stall = 1'b1; #1;
    chk("flush_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_rd", 32'(rd_IDEX), 32'd0);
    chk("flush_memrd", 32'(mem_read_IDEX), 32'd0);
    pc_sel_EXIF = 1'b0; mmm_stall = 1'b0;

    // mmm_stall freezes ID/EX for three cycles.
    drive(ADDI_M3); tick();
    mmm_stall = 1'b1;
    repeat (3) begin
      drive(rand_instr()); tick();
      chk("mmm_hold_imm", imm_IDEX, 32'hFFFFFFFD);
    end
    mmm_stall = 1'b0;
    drive(ADD_USE); tick();
    chk("mmm_release_rd", 32'(rd_IDEX), 32'd4);

    drive(32'h0000007F); tick();
    chk("illegal", 32'(illegal_IDEX), 32'd1);
    chk("illegal_rw", 32'(reg_write_IDEX), 32'd0);
    chk("illegal_memrd", 32'(mem_read_IDEX), 32'd0);

    // Asynchronous reset in the middle of a load-use stall.
    drive(LW_X3); tick();
    drive(ADD_USE); #1;
    chk("rst_pre_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    e = '0;
    #1;
    check_all();
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_stall = 1'b0;

    // Randomized traffic against the reference model.
    repeat (400) begin
      if (!last_stall) drive(rand_instr());
      pc_sel_EXIF = ($urandom_range(0, 9) == 0);
      mmm_stall   = ($urandom_range(0, 7) == 0);
      wb_en       = 1'($urandom);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
